// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction memory for the 8-bit RISC core. A host loads a program
// through a sequential load port, one word per cycle. The block then
// answers pc-addressed fetches with a latency of one cycle.
//
// Optional feature macro: IFU_FETCH_COUNT_EN
//   When it is defined, the block adds the fetch_count port and a
//   saturating counter of in-range RUN-state fetches.
//
// Parameters:
//   DEPTH : number of instruction words (power of two, <= 256)
//   AW    : address width, log2(DEPTH)
//   NOP   : filler word returned for out-of-program fetches
//
// Ports:
//   clk          in  : rising-edge clock
//   reset        in  : synchronous active-high reset
//   load_start   in  : opens (or restarts) a load session
//   load_valid   in  : load_data is valid this cycle
//   load_data    in  : instruction word to store
//   load_done    in  : closes the load session
//   load_ready   out : in LOAD with free space
//   pc           in  : fetch address
//   fetch_req    in  : fetch request
//   instruction  out : fetched word
//   instr_valid  out : instruction holds a real program word
//   prog_len     out : number of words loaded
//   past_end     out : last fetch addressed at or beyond prog_len
//   overflow     out : sticky, a write was attempted while memory was full
//   fetch_count  out : (IFU_FETCH_COUNT_EN only) in-range fetch counter
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int         DEPTH = 16,
  parameter int         AW    = 4,
  parameter logic [7:0] NOP   = 8'h40
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  input  logic          load_done,
  output logic          load_ready,
  input  logic [7:0]    pc,
  input  logic          fetch_req,
  output logic [7:0]    instruction,
  output logic          instr_valid,
  output logic [AW:0]   prog_len,
`ifdef IFU_FETCH_COUNT_EN
  output logic [15:0]   fetch_count,
`endif
  output logic          past_end,
  output logic          overflow
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  state_e        state_q, state_d;
  logic [AW:0]   prog_len_q, prog_len_d;
  logic          overflow_q, overflow_d;
  logic          load_ready_q;
  logic [7:0]    instr_q;
  logic          instr_valid_q;
  logic          past_end_q;
  logic          wr_en_s;
  logic          hit_s;
  logic [7:0]    mem_q [DEPTH];

  // A fetch hits only in RUN. All 8 bits of pc are compared, so
  // addresses beyond DEPTH never alias back into the program.
  assign hit_s = (state_q == ST_RUN) && ({1'b0, pc} < 9'(prog_len_q));

  // Next-state logic for the load session. load_start has priority
  // over everything else, and load_done looks at the post-write length.
  always_comb begin
    state_d    = state_q;
    prog_len_d = prog_len_q;
    overflow_d = overflow_q;
    wr_en_s    = 1'b0;
    if (load_start) begin
      state_d    = ST_LOAD;
      prog_len_d = '0;
      overflow_d = 1'b0;
    end else if (state_q == ST_LOAD) begin
      if (load_valid) begin
        if (prog_len_q < DEPTH_L) begin
          wr_en_s    = 1'b1;
          prog_len_d = prog_len_q + ONE_L;
        end else begin
          overflow_d = 1'b1;
        end
      end else begin
        prog_len_d = prog_len_q;
      end
      if (load_done) begin
        state_d = (prog_len_d != '0) ? ST_RUN : ST_EMPTY;
      end else begin
        state_d = ST_LOAD;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Program storage. It is deliberately not reset, so old contents survive.
  always_ff @(posedge clk) begin
    if (!reset && wr_en_s) begin
      mem_q[prog_len_q[AW-1:0]] <= load_data;
    end
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_EMPTY;
      prog_len_q    <= '0;
      overflow_q    <= 1'b0;
      load_ready_q  <= 1'b0;
      instr_q       <= NOP;
      instr_valid_q <= 1'b0;
      past_end_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prog_len_q   <= prog_len_d;
      overflow_q   <= overflow_d;
      load_ready_q <= (state_d == ST_LOAD) && (prog_len_d < DEPTH_L);
      // Fetches are answered using the state sampled on this edge.
      if (fetch_req) begin
        instr_q       <= hit_s ? mem_q[pc[AW-1:0]] : NOP;
        instr_valid_q <= hit_s;
        past_end_q    <= !hit_s;
      end
    end
  end

`ifdef IFU_FETCH_COUNT_EN
  logic [15:0] fetch_count_q;

  // Saturating count of in-range RUN fetches. A new session clears it.
  always_ff @(posedge clk) begin
    if (reset || load_start) begin
      fetch_count_q <= 16'h0000;
    end else if (fetch_req && hit_s && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_q <= fetch_count_q + 16'h0001;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

  assign load_ready  = load_ready_q;
  assign instruction = instr_q;
  assign instr_valid = instr_valid_q;
  assign prog_len    = prog_len_q;
  assign past_end    = past_end_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic       clk;
  logic       reset;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_done;
  logic       load_ready;
  logic [7:0] pc;
  logic       fetch_req;
  logic [7:0] instruction;
  logic       instr_valid;
  logic [4:0] prog_len;
  logic       past_end;
  logic       overflow;
`ifdef IFU_FETCH_COUNT_EN
  logic [15:0] fetch_count;
`endif

  int n_checks;
  int n_fail;

  logic [7:0] prog10 [10];

  instr_fetch_unit #(.DEPTH(16), .AW(4), .NOP(8'h40)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_done   (load_done),
    .load_ready  (load_ready),
    .pc          (pc),
    .fetch_req   (fetch_req),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .prog_len    (prog_len),
`ifdef IFU_FETCH_COUNT_EN
    .fetch_count (fetch_count),
`endif
    .past_end    (past_end),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // One clock edge. Outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [7:0] addr);
    pc = addr;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
  endtask

  task automatic check_fetch(input string tag, input logic [7:0] ins, input logic v, input logic pe);
    check_eq({tag, ".instr"}, 32'(instruction), 32'(ins));
    check_eq({tag, ".valid"}, 32'(instr_valid), 32'(v));
    check_eq({tag, ".past_end"}, 32'(past_end), 32'(pe));
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    prog10 = '{8'h43, 8'h43, 8'h43, 8'h41, 8'h54, 8'h68, 8'h8F, 8'h29, 8'h55, 8'hC7};
    reset = 1'b1;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data = 8'h00;
    load_done = 1'b0;
    pc = 8'h00;
    fetch_req = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check_fetch("rst", 8'h40, 1'b0, 1'b0);
    check_eq("rst.prog_len", 32'(prog_len), 32'd0);
    check_eq("rst.overflow", 32'(overflow), 32'd0);
    check_eq("rst.load_ready", 32'(load_ready), 32'd0);
`ifdef IFU_FETCH_COUNT_EN
    check_eq("rst.fetch_count", 32'(fetch_count), 32'd0);
`endif

    // Fetch while EMPTY
    fetch(8'h00);
    check_fetch("empty_fetch", 8'h40, 1'b0, 1'b1);
    check_eq("empty.prog_len", 32'(prog_len), 32'd0);

    // Load a 10-word program
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check_eq("load.ready0", 32'(load_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1;
      load_data = prog10[i];
      step();
    end
    load_valid = 1'b0;
    check_eq("load10.prog_len", 32'(prog_len), 32'd10);
    // A fetch on the same edge as load_done is still answered as LOAD.
    load_done = 1'b1;
    pc = 8'h00;
    fetch_req = 1'b1;
    step();
    load_done = 1'b0;
    fetch_req = 1'b0;
    check_fetch("done_edge", 8'h40, 1'b0, 1'b1);
    check_eq("run.load_ready", 32'(load_ready), 32'd0);

    fetch(8'h06);
    check_fetch("pc6", 8'h8F, 1'b1, 1'b0);
    check_eq("run.prog_len", 32'(prog_len), 32'd10);
    fetch(8'h0A);
    check_fetch("pc10", 8'h40, 1'b0, 1'b1);
    fetch(8'hF3);
    check_fetch("pcF3", 8'h40, 1'b0, 1'b1);
    fetch(8'h09);
    check_fetch("pc9", 8'hC7, 1'b1, 1'b0);
    pc = 8'h00;
    step();
    check_fetch("hold", 8'hC7, 1'b1, 1'b0);
    fetch(8'h03);
    check_fetch("pc3", 8'h41, 1'b1, 1'b0);

    // Fill to DEPTH and then overflow
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check_eq("reload.prog_len", 32'(prog_len), 32'd0);
    for (int i = 0; i < 17; i++) begin
      load_valid = 1'b1;
      load_data = 8'(8'hA0 + i);
      step();
      if (i == 15) begin
        check_eq("w16.prog_len", 32'(prog_len), 32'd16);
        check_eq("w16.load_ready", 32'(load_ready), 32'd0);
        check_eq("w16.overflow", 32'(overflow), 32'd0);
      end
    end
    load_valid = 1'b0;
    check_eq("w17.prog_len", 32'(prog_len), 32'd16);
    check_eq("w17.overflow", 32'(overflow), 32'd1);
    load_done = 1'b1;
    step();
    load_done = 1'b0;
    fetch(8'h0F);
    check_fetch("full_pc15", 8'hAF, 1'b1, 1'b0);
    fetch(8'h10);
    check_fetch("full_pc16", 8'h40, 1'b0, 1'b1);
    check_eq("run.overflow_sticky", 32'(overflow), 32'd1);

    // load_start together with load_valid: start wins, overflow cleared
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data = 8'hEE;
    step();
    load_start = 1'b0;
    load_valid = 1'b0;
    check_eq("start_valid.prog_len", 32'(prog_len), 32'd0);
    check_eq("start_valid.overflow", 32'(overflow), 32'd0);
    check_eq("start_valid.load_ready", 32'(load_ready), 32'd1);

    // Reset on the cycle of the 3rd load word
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data = 8'(8'h10 + i);
      reset = (i == 2);
      step();
    end
    load_valid = 1'b0;
    reset = 1'b0;
    check_eq("midrst.prog_len", 32'(prog_len), 32'd0);
    check_eq("midrst.load_ready", 32'(load_ready), 32'd0);
    fetch(8'h00);
    check_fetch("midrst_fetch", 8'h40, 1'b0, 1'b1);
    // load_valid outside LOAD is ignored
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    check_eq("empty_valid.prog_len", 32'(prog_len), 32'd0);
    check_eq("empty_valid.overflow", 32'(overflow), 32'd0);

    // load_valid together with load_done: the word lands, then RUN
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_done = 1'b1;
    load_data = 8'h5A;
    step();
    load_valid = 1'b0;
    load_done = 1'b0;
    check_eq("valid_done.prog_len", 32'(prog_len), 32'd1);
    fetch(8'h00);
    check_fetch("valid_done_fetch", 8'h5A, 1'b1, 1'b0);

`ifdef IFU_FETCH_COUNT_EN
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data = 8'(8'h20 + i);
      step();
    end
    load_valid = 1'b0;
    load_done = 1'b1;
    step();
    load_done = 1'b0;
    fetch(8'h00);
    fetch(8'h01);
    fetch(8'h02);
    fetch(8'h03);
    fetch(8'h07);
    check_eq("fc.count4", 32'(fetch_count), 32'd4);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check_eq("fc.cleared", 32'(fetch_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-memory responder for the 8-bit RISC core: holds the program and answers the core's `pc`-addressed fetches with 8-bit instruction words. Programs are written through a sequential load port by a host or bench loader, and the block then serves fetches. It sits between the program loader and the `cpu` `instruction` input, replacing bench-side `case (pc)` instruction generation.

## Interface
- `DEPTH`, default 16: number of instruction words; power of two, ≤ 256.
- `AW`, default 4: address width, equal to log2(`DEPTH`).
- `NOP`, default 8'h40: filler word, which decodes as ADDI R0,R0,0.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `load_start` in 1: pulse that opens a load session.
- `load_valid` in 1: `load_data` is valid this cycle.
- `load_data` in 8: instruction word to store.
- `load_done` in 1: pulse that closes the load session.
- `load_ready` out 1: high while in LOAD with free space.
- `pc` in 8: fetch address from the core.
- `fetch_req` in 1: fetch request.
- `instruction` out 8: fetched word.
- `instr_valid` out 1: `instruction` holds a real program word.
- `prog_len` out AW+1: number of words loaded.
- `past_end` out 1: last fetch addressed at or beyond `prog_len`.
- `overflow` out 1: sticky; a write was attempted while memory was full.
- `fetch_count` out 16: present only with `IFU_FETCH_COUNT_EN`.

## Operation
State machine has three states: EMPTY, LOAD and RUN.
- Reset values:
  - State is EMPTY.
  - `prog_len` = 0, `instruction` = `NOP`.
  - `instr_valid`, `past_end`, `overflow` and `load_ready` are 0.
  - `fetch_count` = 0.
  - Memory contents are not cleared.
- EMPTY →LOAD on `load_start`. Fetches are answered with `NOP`, `instr_valid`=0 and `past_end`=1.
- LOAD behaviour:
  - Write pointer = `prog_len`.
  - `load_valid` with `prog_len` < `DEPTH` stores `load_data` at `mem[prog_len]` and increments `prog_len`.
  - `load_valid` with `prog_len` = `DEPTH` drops the word and sets `overflow`.
  - `load_ready` = (`prog_len` < `DEPTH`).
  - `load_done` moves to RUN if `prog_len` > 0, else to EMPTY.
  - Fetches are answered as in EMPTY.
- RUN behaviour:
  - When `fetch_req` is high, the fetch returns `mem[pc]` with `instr_valid`=1 and `past_end`=0 if `pc` < `prog_len`.
  - Otherwise it returns `NOP` with `instr_valid`=0 and `past_end`=1.
  - All 8 bits of `pc` are compared, so no aliasing across `DEPTH`.
  - `load_start` returns the block to LOAD and sets `prog_len`=0. Old contents remain but are unreachable until rewritten.
- Cycle with no `fetch_req`: `instruction`, `instr_valid` and `past_end` hold their previous values.
- Simultaneous events:
  - `load_start` together with `load_valid`: start wins, the data is ignored, and `overflow` is cleared.
  - `load_valid` together with `load_done`: the word is written first, then the transition occurs using the updated `prog_len`.
  - `load_start` in LOAD restarts the session (`prog_len`=0).
  - `load_done` outside LOAD is ignored.
  - `load_valid` outside LOAD is ignored and does not set `overflow`.
- Reset mid-load or mid-run: all outputs return to reset values on that edge, and pending load or fetch results are discarded.

## Timing
- Fetch latency is 1 cycle: a request sampled at edge N drives `instruction`, `instr_valid` and `past_end` after edge N. The core samples them on edge N+1.
- Load throughput is one word per cycle. `prog_len` updates on the edge that samples `load_valid`.
- `load_ready` is registered-state derived and changes the cycle after the write that fills memory.
- State transitions take effect on the sampling edge. A fetch sampled on the same edge as `load_done` is still answered as LOAD.

## Configuration
- `IFU_FETCH_COUNT_EN` defined:
  - `fetch_count` port exists and increments by 1 on every RUN-state fetch with `pc` < `prog_len`.
  - It saturates at 16'hFFFF and clears on `reset` or `load_start`.
- Not defined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Reset then fetch `pc`=0 → `instruction`=8'h40, `instr_valid`=0, `past_end`=1, `prog_len`=0.
- Load 10 words (8'h43, 43, 43, 41, 54, 68, 8F, 29, 55, C7), then `load_done`, then fetch `pc`=6 → next cycle `instruction`=8'h8F, `instr_valid`=1; `prog_len`=10.
- After loading 10 words, fetch `pc`=10 and `pc`=8'hF3 → `NOP`, `past_end`=1, `instr_valid`=0 in both cases.
- Write 17 words with `DEPTH`=16 → `prog_len`=16, `load_ready`=0 after the 16th word, `overflow`=1 after the 17th, and `mem[15]` holds the 16th word.
- Assert `reset` on the cycle of the 3rd load word → `prog_len`=0, state EMPTY; a following `pc`=0 fetch returns `NOP`.
- With `IFU_FETCH_COUNT_EN`, load 4 words and fetch `pc` = 0, 1, 2, 3, 7 → `fetch_count`=4; a new `load_start` clears it to 0.
